// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending collector.
package irq_pkg;
  localparam int N_REQ_DEF = 8;
  localparam int IDX_W_DEF = 3;
  localparam logic [N_REQ_DEF-1:0] MASK_RST_DEF = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } coll_state_e;
endpackage

// File: rtl/req_edge_det.sv
// Rising-edge detector: registers the request lines and flags 0->1 transitions.
module req_edge_det #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] req,
  output logic [W-1:0] rise
);
  logic [W-1:0] req_q;
  logic [W-1:0] req_d;

  always_comb begin
    req_d = req;
  end

  // Reset to 0 so a request held high across reset release counts as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req_d;
  end

  assign rise = req & ~req_q;
endmodule

// File: rtl/irq_pending_collector.sv
// Captures request edges into sticky pending bits, applies a mask and hands a
// frozen snapshot to the priority encoder until the serviced index is acked.
module irq_pending_collector
  import irq_pkg::*;
#(
  parameter int               N_REQ    = N_REQ_DEF,
  parameter int               IDX_W    = IDX_W_DEF,
  parameter logic [N_REQ-1:0] MASK_RST = MASK_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_wdata,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [N_REQ-1:0] vec_o,
  output logic             vec_vld,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf,
  output logic             ack_err
);
  // Handshake: vec_o is valid while vec_vld=1 and stays frozen until an ack
  // whose ack_idx selects a set bit of vec_o; any other ack in HOLD is an error.
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] ovf_set;
  logic [N_REQ-1:0] enabled;
  logic             ack_hit;

  coll_state_e      state_q;
  logic [N_REQ-1:0] vec_q;
  logic             vld_q;
  logic             ack_err_q;

  req_edge_det #(.W(N_REQ)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .rise  (rise)
  );

  always_comb begin
    ack_hit = (state_q == HOLD) && ack && vec_q[ack_idx];
    clr     = '0;
    if (ack_hit) clr[ack_idx] = 1'b1;
    // A rise on a bit being cleared re-arms it and is not a lost event.
    pending_d = (pending_q & ~clr) | rise;
    ovf_set   = rise & pending_q & ~clr;
    ovf_d     = (ovf_q & ~{N_REQ{ovf_clr}}) | ovf_set;
    mask_d    = mask_we ? mask_wdata : mask_q;
    enabled   = pending_q & mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
      mask_q    <= MASK_RST;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      vld_q     <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      ack_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enabled != '0) begin
            vec_q   <= enabled;
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            if (ack_hit) begin
              vec_q   <= '0;
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              ack_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          vec_q   <= '0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign vec_o   = vec_q;
  assign vec_vld = vld_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;
  assign ack_err = ack_err_q;
endmodule

// File: tb/tb_irq_pending_collector.sv
// Directed bench: snapshots are checked by a monitor against an expected queue,
// side outputs (pending, ovf, ack_err) are checked inline by the driver.
module tb_irq_pending_collector;
  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic [2:0] ack_idx;
  logic       ovf_clr;
  logic [7:0] vec_o;
  logic       vec_vld;
  logic [7:0] pending;
  logic [7:0] ovf;
  logic       ack_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       vld_prev = 1'b0;

  irq_pending_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .ovf_clr    (ovf_clr),
    .vec_o      (vec_o),
    .vec_vld    (vec_vld),
    .pending    (pending),
    .ovf        (ovf),
    .ack_err    (ack_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [2:0] idx);
    ack = 1'b1;
    ack_idx = idx;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_req(input logic [7:0] v);
    req = v;
    tick();
    req = 8'h00;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we = 1'b1;
    mask_wdata = v;
    tick();
    mask_we = 1'b0;
  endtask

  // Monitor / scoreboard: every new snapshot must match the queue front.
  always @(negedge clk) begin
    if (rst_n && vec_vld && !vld_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_snapshot", {24'h0, vec_o}, 32'hFFFF_FFFF);
      end else begin
        check("snapshot", {24'h0, vec_o}, {24'h0, exp_q.pop_front()});
      end
    end
    vld_prev = vec_vld;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_vec_vld", {31'h0, vec_vld}, 32'h0);
    check("rst_vec_o", {24'h0, vec_o}, 32'h0);
    check("rst_pending", {24'h0, pending}, 32'h0);
    check("rst_ovf", {24'h0, ovf}, 32'h0);
    check("rst_ack_err", {31'h0, ack_err}, 32'h0);
    tick();

    // Single request, latency and ack
    exp_q.push_back(8'h01);
    pulse_req(8'h01);
    check("t1_pending", {24'h0, pending}, 32'h01);
    check("t1_vld_early", {31'h0, vec_vld}, 32'h0);
    tick();
    check("t1_vld", {31'h0, vec_vld}, 32'h1);
    do_ack(3'd0);
    check("t1_vld_after_ack", {31'h0, vec_vld}, 32'h0);
    check("t1_pending_after_ack", {24'h0, pending}, 32'h0);
    do_ack(3'd0);
    check("idle_ack_no_err", {31'h0, ack_err}, 32'h0);

    // Two simultaneous edges
    exp_q.push_back(8'h22);
    pulse_req(8'h22);
    tick();
    exp_q.push_back(8'h02);
    do_ack(3'd5);
    check("t2_gap", {31'h0, vec_vld}, 32'h0);
    tick();
    check("t2_second", {24'h0, vec_o}, 32'h02);
    do_ack(3'd1);
    check("t2_idle", {31'h0, vec_vld}, 32'h0);
    tick();
    check("t2_stay_idle", {31'h0, vec_vld}, 32'h0);

    // Snapshot frozen while new edge arrives
    exp_q.push_back(8'h04);
    pulse_req(8'h04);
    tick();
    pulse_req(8'h40);
    check("t3_frozen", {24'h0, vec_o}, 32'h04);
    check("t3_pending", {24'h0, pending}, 32'h44);
    tick();
    check("t3_frozen2", {24'h0, vec_o}, 32'h04);
    exp_q.push_back(8'h40);
    do_ack(3'd2);
    tick();
    do_ack(3'd6);

    // Mask behaviour
    write_mask(8'hF0);
    pulse_req(8'h01);
    check("t4_pending_masked", {24'h0, pending}, 32'h01);
    tick(); tick();
    check("t4_vld_masked", {31'h0, vec_vld}, 32'h0);
    exp_q.push_back(8'h01);
    write_mask(8'hFF);
    check("t4_vld_after_write", {31'h0, vec_vld}, 32'h0);
    tick();
    check("t4_vec_unmasked", {24'h0, vec_o}, 32'h01);
    do_ack(3'd0);

    // Overflow
    exp_q.push_back(8'h08);
    pulse_req(8'h08);
    tick();
    pulse_req(8'h08);
    check("t5_ovf", {24'h0, ovf}, 32'h08);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_ovf_clr", {24'h0, ovf}, 32'h0);
    exp_q.push_back(8'h08);
    req = 8'h08;
    do_ack(3'd3);
    req = 8'h00;
    check("t5_rise_wins_pending", {24'h0, pending}, 32'h08);
    check("t5_rise_wins_ovf", {24'h0, ovf}, 32'h0);
    check("t5_gap", {31'h0, vec_vld}, 32'h0);
    tick();
    do_ack(3'd3);
    check("t5_pending_clear", {24'h0, pending}, 32'h0);

    // Bad ack, then reset mid-HOLD
    exp_q.push_back(8'h10);
    pulse_req(8'h10);
    tick();
    do_ack(3'd2);
    check("t6_ack_err", {31'h0, ack_err}, 32'h1);
    check("t6_still_hold", {31'h0, vec_vld}, 32'h1);
    check("t6_vec_kept", {24'h0, vec_o}, 32'h10);
    tick();
    check("t6_ack_err_pulse", {31'h0, ack_err}, 32'h0);
    write_mask(8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", {31'h0, vec_vld}, 32'h0);
    check("t6_rst_vec", {24'h0, vec_o}, 32'h0);
    check("t6_rst_pending", {24'h0, pending}, 32'h0);
    tick();
    rst_n = 1'b1;
    exp_q.push_back(8'h80);
    pulse_req(8'h80);
    tick();
    check("t6_mask_reset", {24'h0, vec_o}, 32'h80);
    do_ack(3'd7);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
